// File: rtl/inst_encoder_if.sv
// Field-bundle in / encoded-word out handshake bundle for inst_encoder.
// The encoder is the slave; the loader or bench driving it is the master.
interface inst_encoder_if #(
    parameter int INST_WIDTH = 32,
    parameter int IMM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [IMM_WIDTH-1:0]  imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_inst;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;
    logic [15:0]           err_count;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I field encoder: packs opcode/regs/funct/immediate into one word,
// with a registered output slot, word-address counter and error counter.
module inst_encoder #(
    parameter int INST_WIDTH = 32,
    parameter int IMM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    inst_encoder_if.slave  bus
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic signed [IMM_WIDTH-1:0] I_MIN = -2048;
    localparam logic signed [IMM_WIDTH-1:0] I_MAX = 2047;
    localparam logic signed [IMM_WIDTH-1:0] B_MIN = -4096;
    localparam logic signed [IMM_WIDTH-1:0] B_MAX = 4094;
    localparam logic signed [IMM_WIDTH-1:0] J_MIN = -(1 << 20);
    localparam logic signed [IMM_WIDTH-1:0] J_MAX = (1 << 20) - 2;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    fmt_e                        fmt;
    logic signed [IMM_WIDTH-1:0] simm;
    logic [IMM_WIDTH-1:0]        imm;
    logic [INST_WIDTH-1:0]       enc_inst;
    logic                        enc_err;

    logic                  out_valid_q, out_valid_d;
    logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_err_q, out_err_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic in_ready;
    logic accept;
    logic out_hs;

    assign imm  = bus.imm;
    assign simm = $signed(bus.imm);

    always_comb begin
        fmt = FMT_BAD;
        unique case (bus.opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_JAL:                   fmt = FMT_J;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_REG:                   fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
    end

    // Out-of-range immediates still produce the truncated word; only the flag differs.
    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b1;
        unique case (fmt)
            FMT_I: begin
                enc_inst = {imm[11:0], bus.rs1, bus.funct3,
                            bus.rd, bus.opcode};
                enc_err  = (simm < I_MIN) || (simm > I_MAX);
            end
            FMT_S: begin
                enc_inst = {imm[11:5], bus.rs2, bus.rs1,
                            bus.funct3, imm[4:0], bus.opcode};
                enc_err  = (simm < I_MIN) || (simm > I_MAX);
            end
            FMT_B: begin
                enc_inst = {imm[12], imm[10:5], bus.rs2, bus.rs1,
                            bus.funct3, imm[4:1], imm[11], bus.opcode};
                enc_err  = imm[0] || (simm < B_MIN) || (simm > B_MAX);
            end
            FMT_J: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12],
                            bus.rd, bus.opcode};
                enc_err  = imm[0] || (simm < J_MIN) || (simm > J_MAX);
            end
            FMT_U: begin
                enc_inst = {imm[31:12], bus.rd, bus.opcode};
                enc_err  = |imm[11:0];
            end
            FMT_R: begin
                enc_inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3,
                            bus.rd, bus.opcode};
                enc_err  = 1'b0;
            end
            default: begin
                enc_inst = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready = !clear && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        if (clear) begin
            out_valid_d = 1'b0;
            out_addr_d  = '0;
            err_cnt_d   = '0;
        end else begin
            if (out_hs) begin
                out_addr_d = out_addr_q + ADDR_WIDTH'(4);
                if (out_err_q && (err_cnt_q != 16'hFFFF))
                    err_cnt_d = err_cnt_q + 16'd1;
            end
            if (accept) begin
                out_valid_d = 1'b1;
                out_inst_d  = enc_inst;
                out_err_d   = enc_err;
            end else if (out_hs) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: fixed vector table, stall/clear/reset sequences,
// and a randomized run against an arithmetic reference model.
module tb_inst_encoder;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    inst_encoder_if bus ();

    inst_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [31:0] imm;
        logic        chk_imm;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.in_valid = valid;
        bus.opcode   = v.op;
        bus.rd       = v.rd;
        bus.rs1      = v.rs1;
        bus.rs2      = v.rs2;
        bus.funct3   = v.f3;
        bus.funct7   = v.f7;
        bus.imm      = v.imm;
    endtask

    // Reference encoder built from field positions with shifts and masks.
    function automatic void ref_enc(input vec_t v, output logic [31:0] w,
                                    output logic err);
        int unsigned u, rd, r1, r2, f3, f7, op;
        int s;
        u  = v.imm;
        s  = $signed(v.imm);
        rd = 32'(v.rd);
        r1 = 32'(v.rs1);
        r2 = 32'(v.rs2);
        f3 = 32'(v.f3);
        f7 = 32'(v.f7);
        op = 32'(v.op);
        w  = 0;
        err = 1'b1;
        case (v.op)
            7'h13, 7'h03, 7'h67: begin
                w = ((u & 'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
                err = (s < -2048) || (s > 2047);
            end
            7'h23: begin
                w = (((u >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15)
                  | (f3 << 12) | ((u & 'h1F) << 7) | op;
                err = (s < -2048) || (s > 2047);
            end
            7'h63: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25)
                  | (r2 << 20) | (r1 << 15) | (f3 << 12)
                  | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | op;
                err = ((u & 1) != 0) || (s < -4096) || (s > 4094);
            end
            7'h6F: begin
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
                  | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12)
                  | (rd << 7) | op;
                err = ((u & 1) != 0) || (s < -1048576) || (s > 1048574);
            end
            7'h37, 7'h17: begin
                w = (u & 'hFFFFF000) | (rd << 7) | op;
                err = (u & 'hFFF) != 0;
            end
            7'h33: begin
                w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
                err = 1'b0;
            end
            default: begin
                w = 0;
                err = 1'b1;
            end
        endcase
    endfunction

    // Decode-stage immediate extender, used for the round-trip property.
    function automatic logic [31:0] imm_ext(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: r = {{20{w[31]}}, w[31:20]};
            7'h23: r = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            7'h37, 7'h17: r = {w[31:12], 12'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int k;
        logic [6:0] legal [9];
        logic [6:0] bad [4];
        legal = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
        bad   = '{7'h7F, 7'h00, 7'h0F, 7'h73};
        k = $urandom_range(0, 9);
        v.op  = (k < 9) ? legal[k] : bad[$urandom_range(0, 3)];
        v.rd  = 5'($urandom);
        v.rs1 = 5'($urandom);
        v.rs2 = 5'($urandom);
        v.f3  = 3'($urandom);
        v.f7  = 7'($urandom);
        case (v.op)
            7'h63: v.imm = 32'(2 * ($signed($urandom_range(0, 4095)) - 2048));
            7'h6F: v.imm = 32'(2 * ($signed($urandom_range(0, 1048575)) - 524288));
            7'h37, 7'h17: v.imm = $urandom & 32'hFFFFF000;
            default: v.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        endcase
        if ($urandom_range(0, 3) == 0)
            v.imm = $urandom;
        v.inst = '0;
        v.err  = 1'b0;
        return v;
    endfunction

    vec_t tbl [11];
    vec_t v;
    exp_t e;
    exp_t pend [$];
    logic [31:0] mw;
    logic merr;
    int nhs;
    int errcnt;
    logic iv, ordy, exp_rdy;

    initial begin
        tbl[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
        tbl[1]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,        32'h00208463, 1'b0};
        tbl[2]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0};
        tbl[3]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF, 1'b0};
        tbl[4]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
        tbl[5]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0,        32'h002081B3, 1'b0};
        tbl[6]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'd0, 32'h00000403, 32'h40315093, 1'b0};
        tbl[7]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000093, 1'b1};
        tbl[8]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        32'h00208163, 1'b1};
        tbl[9]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001, 32'h000002B7, 1'b1};
        tbl[10] = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'h0,        32'h00000000, 1'b1};

        rst_n = 1'b0;
        clear = 1'b0;
        drive(tbl[0], 1'b0);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_inst", bus.out_inst, 0);
        chk("rst_addr", 32'(bus.out_addr), 0);
        chk("rst_err", bus.out_err, 0);
        chk("rst_errcnt", 32'(bus.err_count), 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", bus.in_ready, 1);

        // Back-to-back stream of the fixed vectors.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i], 1'b1);
            step();
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("tbl%0d_inst", i), bus.out_inst, tbl[i].inst);
            chk($sformatf("tbl%0d_err", i), bus.out_err, tbl[i].err);
            chk($sformatf("tbl%0d_addr", i), 32'(bus.out_addr), 32'(i * 4));
            if (!tbl[i].err && tbl[i].op != 7'h33)
                chk($sformatf("tbl%0d_roundtrip", i), imm_ext(bus.out_inst), tbl[i].imm);
        end
        bus.in_valid = 1'b0;
        step();
        chk("tbl_drain_valid", bus.out_valid, 0);
        chk("tbl_errcnt", 32'(bus.err_count), 4);
        chk("tbl_drain_addr", 32'(bus.out_addr), 44);

        // Stall with input held, then resume.
        bus.out_ready = 1'b0;
        drive(tbl[0], 1'b1);
        step();
        drive(tbl[5], 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("stall_in_ready", bus.in_ready, 0);
            step();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_inst", bus.out_inst, 32'hFFF00093);
            chk("stall_addr", 32'(bus.out_addr), 44);
        end
        bus.out_ready = 1'b1;
        step();
        chk("resume_inst", bus.out_inst, 32'h002081B3);
        chk("resume_addr", 32'(bus.out_addr), 48);
        bus.in_valid = 1'b0;
        step();
        chk("resume_nodup", bus.out_valid, 0);
        chk("resume_addr2", 32'(bus.out_addr), 52);

        // Clear during a stall drops the held word and zeroes counters.
        bus.out_ready = 1'b0;
        drive(tbl[7], 1'b1);
        step();
        chk("preclr_err", bus.out_err, 1);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("clr_in_ready", bus.in_ready, 0);
        step();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_valid", bus.out_valid, 0);
        chk("clr_addr", 32'(bus.out_addr), 0);
        chk("clr_errcnt", 32'(bus.err_count), 0);

        // Randomized traffic against the reference model.
        nhs = 0;
        errcnt = 0;
        pend.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_valid", bus.out_valid, 32'(pend.size() != 0));
            if (pend.size() != 0) begin
                chk("rnd_inst", bus.out_inst, pend[0].inst);
                chk("rnd_err", bus.out_err, pend[0].err);
                chk("rnd_addr", 32'(bus.out_addr), 32'((nhs * 4) % 4096));
                if (pend[0].chk_imm)
                    chk("rnd_roundtrip", imm_ext(bus.out_inst), pend[0].imm);
            end
            chk("rnd_errcnt", 32'(bus.err_count), 32'(errcnt));
            v = rand_vec();
            iv = ($urandom_range(0, 7) != 0);
            ordy = ($urandom_range(0, 7) != 0);
            drive(v, iv);
            bus.out_ready = ordy;
            #1;
            exp_rdy = (pend.size() == 0) || ordy;
            chk("rnd_in_ready", bus.in_ready, 32'(exp_rdy));
            if ((pend.size() != 0) && ordy) begin
                e = pend.pop_front();
                nhs++;
                if (e.err && errcnt < 65535)
                    errcnt++;
            end
            if (iv && exp_rdy) begin
                ref_enc(v, mw, merr);
                e.inst = mw;
                e.err = merr;
                e.imm = v.imm;
                e.chk_imm = !merr && (v.op != 7'h33);
                pend.push_back(e);
            end
            step();
        end
        chk("rnd_wrapped", 32'(nhs >= 1024), 1);

        // Reset mid-stream discards a stalled word.
        bus.out_ready = 1'b0;
        drive(tbl[8], 1'b1);
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_inst", bus.out_inst, 0);
        chk("mrst_addr", 32'(bus.out_addr), 0);
        chk("mrst_err", bus.out_err, 0);
        chk("mrst_errcnt", 32'(bus.err_count), 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
